// File: rtl/color_encoder.sv
// ---------------------------------------------------------------------------
// color_encoder
//
// Converts the maria colour index stream into 24-bit RGB. It has a two-stage
// pipeline that advances only on the mclk0 pixel strobe. Stage 1 captures the
// index, the raw timing and the active palette set. Stage 2 looks the pixel up
// in a 2048x24 palette memory and registers the timing alongside the read
// data. The timing outputs are therefore delay-matched to the RGB outputs.
//
// The palette set {pal, pal_temp} is sampled only on a vsync_in rising edge,
// so a bank switch never tears a frame. Eight built-in palettes are provided:
// NTSC sets 0-3 and PAL sets 4-7. The set index is the top three bits of the
// palette address.
//
// Build option (macro):
//   COLOR_ENCODER_PALETTE_WRITE_EN
//      Defined   : the palette is a RAM preloaded with the built-in palettes,
//                  and pal_wr writes pal_wr_data at pal_wr_addr on any clk_sys
//                  cycle. A read that collides with a write returns the old
//                  word.
//      Undefined : the palette is a ROM. The write ports exist but are
//                  ignored.
//
// Ports:
//   clk_sys      in   1   system clock; every flop uses its rising edge
//   reset_b      in   1   asynchronous active-low reset
//   mclk0        in   1   one-cycle pixel strobe
//   yc           in   8   colour index {hue[7:4], lum[3:0]}
//   hsync_in     in   1   raw horizontal sync
//   vsync_in     in   1   raw vertical sync
//   hblank_in    in   1   raw horizontal blank
//   vblank_in    in   1   raw vertical blank
//   pal          in   1   PAL/NTSC bank select
//   pal_temp     in   2   palette variant within the bank
//   pal_wr       in   1   palette write strobe
//   pal_wr_addr  in   11  {bank, variant[1:0], index[7:0]}
//   pal_wr_data  in   24  {R, G, B}
//   red/green/blue out 8  pixel colour (BLANK_RGB while blanked)
//   hsync/vsync  out  1   sync, aligned with RGB
//   hblank/vblank out 1   blank, aligned with RGB
//   ce_pix       out  1   one-cycle pulse after each output update
// ---------------------------------------------------------------------------
module color_encoder #(
    parameter logic [23:0] BLANK_RGB = 24'h000000,
    parameter int          LATENCY   = 2
) (
    input  logic        clk_sys,
    input  logic        reset_b,
    input  logic        mclk0,
    input  logic [7:0]  yc,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblank_in,
    input  logic        vblank_in,
    input  logic        pal,
    input  logic [1:0]  pal_temp,
    input  logic        pal_wr,
    input  logic [10:0] pal_wr_addr,
    input  logic [23:0] pal_wr_data,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        hsync,
    output logic        vsync,
    output logic        hblank,
    output logic        vblank,
    output logic        ce_pix
);

    // LATENCY only documents the pipeline depth. The pipeline itself is
    // fixed, so an override would describe hardware that does not exist.
    if (LATENCY != 2) begin : g_latency_check
        $error("color_encoder: LATENCY is fixed at 2");
    end

    localparam int PAL_DEPTH = 2048;

    // Timing bundle order used throughout: {hsync, vsync, hblank, vblank}.
    // The reset value keeps both blanks asserted.
    localparam logic [3:0] TIMING_RESET = 4'b0011;

    // -----------------------------------------------------------------------
    // Built-in palette generator
    //
    // Luma is the 4-bit lum replicated to 8 bits. Each non-zero hue adds a
    // fixed chroma vector. The PAL bank rotates the hue wheel by one step.
    // The variant adds a warm/cool tint: red is shifted by +warm and blue by
    // -warm. Channels saturate to 0..255.
    // -----------------------------------------------------------------------
    function automatic logic [23:0] hue_vector(input logic [3:0] hue);
        logic [23:0] v;    // {cr, cg, cb}, each signed 8-bit
        case (hue)
            4'd1:    v = {8'sd40,  8'sd24,  -8'sd48};
            4'd2:    v = {8'sd48,  8'sd8,   -8'sd40};
            4'd3:    v = {8'sd48,  -8'sd16, -8'sd24};
            4'd4:    v = {8'sd40,  -8'sd32, 8'sd0};
            4'd5:    v = {8'sd32,  -8'sd40, 8'sd24};
            4'd6:    v = {8'sd8,   -8'sd40, 8'sd40};
            4'd7:    v = {-8'sd16, -8'sd32, 8'sd48};
            4'd8:    v = {-8'sd32, -8'sd16, 8'sd48};
            4'd9:    v = {-8'sd40, 8'sd8,   8'sd40};
            4'd10:   v = {-8'sd40, 8'sd24,  8'sd24};
            4'd11:   v = {-8'sd32, 8'sd40,  8'sd0};
            4'd12:   v = {-8'sd16, 8'sd48,  -8'sd16};
            4'd13:   v = {8'sd8,   8'sd48,  -8'sd32};
            4'd14:   v = {8'sd24,  8'sd40,  -8'sd48};
            4'd15:   v = {8'sd40,  8'sd24,  -8'sd48};
            default: v = 24'h000000;
        endcase
        return v;
    endfunction

    function automatic logic [7:0] clamp8(input logic signed [9:0] v);
        logic [7:0] r;
        if (v < 10'sd0) begin
            r = 8'd0;
        end else if (v > 10'sd255) begin
            r = 8'd255;
        end else begin
            r = v[7:0];
        end
        return r;
    endfunction

    function automatic logic [23:0] palette_entry(input logic [10:0] addr);
        logic              bank;
        logic [1:0]        variant;
        logic [3:0]        hue;
        logic [3:0]        lum;
        logic [3:0]        eff_hue;
        logic [23:0]       vec;
        logic signed [9:0] luma;
        logic signed [9:0] warm;
        logic signed [7:0] cr;
        logic signed [7:0] cg;
        logic signed [7:0] cb;
        bank    = addr[10];
        variant = addr[9:8];
        hue     = addr[7:4];
        lum     = addr[3:0];
        // Grey (hue 0) is not rotated. Hue 15 wraps to 1 so that it never
        // lands on the grey column.
        if (bank && (hue != 4'd0)) begin
            eff_hue = (hue == 4'd15) ? 4'd1 : hue + 4'd1;
        end else begin
            eff_hue = hue;
        end
        case (variant)
            2'd1:    warm = 10'sd8;
            2'd2:    warm = -10'sd8;
            2'd3:    warm = 10'sd16;
            default: warm = 10'sd0;
        endcase
        vec  = hue_vector(eff_hue);
        cr   = vec[23:16];
        cg   = vec[15:8];
        cb   = vec[7:0];
        luma = $signed({2'b00, lum, lum});
        return {clamp8(luma + 10'(cr) + warm),
                clamp8(luma + 10'(cg)),
                clamp8(luma + 10'(cb) - warm)};
    endfunction

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    logic [2:0]  set_sel_q,    set_sel_d;
    logic        vsync_prev_q, vsync_prev_d;
    logic [7:0]  yc_s1_q,      yc_s1_d;
    logic [2:0]  set_s1_q,     set_s1_d;
    logic [3:0]  timing_s1_q,  timing_s1_d;
    logic [3:0]  timing_s2_q,  timing_s2_d;
    logic [23:0] rgb_s2_q,     rgb_s2_d;
    logic        ce_pix_q,     ce_pix_d;

    logic [10:0] rd_addr;
    logic [23:0] rd_word;
    logic        vsync_rise;

    // Concatenation, not addition: a full index can never carry into the
    // set bits.
    assign rd_addr = {set_s1_q, yc_s1_q};

    // -----------------------------------------------------------------------
    // Palette storage
    // -----------------------------------------------------------------------
`ifdef COLOR_ENCODER_PALETTE_WRITE_EN
    typedef logic [23:0] pal_array_t [0:PAL_DEPTH-1];

    function automatic pal_array_t build_palette();
        pal_array_t p;
        for (int i = 0; i < PAL_DEPTH; i++) begin
            p[i] = palette_entry(11'(i));
        end
        return p;
    endfunction

    // Preloaded contents have no reset, so reset leaves the palette intact.
    pal_array_t pal_mem = build_palette();

    always_ff @(posedge clk_sys) begin
        if (pal_wr) begin
            pal_mem[pal_wr_addr] <= pal_wr_data;
        end
    end

    // The read is sampled on the same edge as any write. It therefore sees
    // the pre-write word, which gives read-first collision behaviour.
    assign rd_word = pal_mem[rd_addr];
`else
    logic unused_wr_port;

    assign unused_wr_port = ^{pal_wr, pal_wr_addr, pal_wr_data};
    assign rd_word        = palette_entry(rd_addr);
`endif

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    assign vsync_rise = mclk0 && vsync_in && !vsync_prev_q;

    always_comb begin
        set_sel_d    = set_sel_q;
        vsync_prev_d = vsync_prev_q;
        yc_s1_d      = yc_s1_q;
        set_s1_d     = set_s1_q;
        timing_s1_d  = timing_s1_q;
        timing_s2_d  = timing_s2_q;
        rgb_s2_d     = rgb_s2_q;
        ce_pix_d     = mclk0;

        if (mclk0) begin
            vsync_prev_d = vsync_in;
            // {pal, pal_temp} are sampled on the rising strobe itself, so
            // a change on the same strobe as the vsync edge takes effect.
            if (vsync_rise) begin
                set_sel_d = {pal, pal_temp};
            end
            // The pixel captured on the vsync edge already uses the new set.
            yc_s1_d     = yc;
            set_s1_d    = set_sel_d;
            timing_s1_d = {hsync_in, vsync_in, hblank_in, vblank_in};
            timing_s2_d = timing_s1_q;
            rgb_s2_d    = rd_word;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_b) begin
        if (!reset_b) begin
            set_sel_q    <= 3'd0;
            vsync_prev_q <= 1'b0;
            yc_s1_q      <= 8'd0;
            set_s1_q     <= 3'd0;
            timing_s1_q  <= TIMING_RESET;
            timing_s2_q  <= TIMING_RESET;
            rgb_s2_q     <= BLANK_RGB;
            ce_pix_q     <= 1'b0;
        end else begin
            set_sel_q    <= set_sel_d;
            vsync_prev_q <= vsync_prev_d;
            yc_s1_q      <= yc_s1_d;
            set_s1_q     <= set_s1_d;
            timing_s1_q  <= timing_s1_d;
            timing_s2_q  <= timing_s2_d;
            rgb_s2_q     <= rgb_s2_d;
            ce_pix_q     <= ce_pix_d;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    logic [23:0] rgb_out;

    // The blank substitution works from the stage-2 flags, which are reset
    // high. An asynchronous reset therefore blanks the picture immediately.
    assign rgb_out = (timing_s2_q[1] || timing_s2_q[0]) ? BLANK_RGB : rgb_s2_q;

    assign red    = rgb_out[23:16];
    assign green  = rgb_out[15:8];
    assign blue   = rgb_out[7:0];
    assign hsync  = timing_s2_q[3];
    assign vsync  = timing_s2_q[2];
    assign hblank = timing_s2_q[1];
    assign vblank = timing_s2_q[0];
    assign ce_pix = ce_pix_q;

endmodule

// File: tb/tb_color_encoder.sv
module tb_color_encoder;

    logic        clk_sys;
    logic        reset_b;
    logic        mclk0;
    logic [7:0]  yc;
    logic        hsync_in, vsync_in, hblank_in, vblank_in;
    logic        pal;
    logic [1:0]  pal_temp;
    logic        pal_wr;
    logic [10:0] pal_wr_addr;
    logic [23:0] pal_wr_data;
    logic [7:0]  red, green, blue;
    logic        hsync, vsync, hblank, vblank;
    logic        ce_pix;
    logic [23:0] rgb;

    int n_checks = 0;
    int n_fail   = 0;

    // Hand-computed built-in palette entries.
    localparam logic [23:0] S0_0F = 24'hFFFFFF;
    localparam logic [23:0] S0_1A = 24'hD2C27A;
    localparam logic [23:0] S0_35 = 24'h85453D;
    localparam logic [23:0] S0_FF = 24'hFFFFCF;
    localparam logic [23:0] S4_1A = 24'hDAB282;
    localparam logic [23:0] S4_35 = 24'h7D3555;
    localparam logic [23:0] S1_1A = 24'hDAC272;
    localparam logic [23:0] S1_35 = 24'h8D4535;
    localparam logic [23:0] S1_FF = 24'hFFFFC7;
    localparam logic [23:0] BLANK = 24'h000000;

`ifdef COLOR_ENCODER_PALETTE_WRITE_EN
    localparam logic [23:0] EXP_FF_NEW = 24'h123456;
    localparam logic [23:0] EXP_1A_NEW = 24'hABCDEF;
`else
    localparam logic [23:0] EXP_FF_NEW = S0_FF;
    localparam logic [23:0] EXP_1A_NEW = S0_1A;
`endif

    color_encoder dut (
        .clk_sys     (clk_sys),
        .reset_b     (reset_b),
        .mclk0       (mclk0),
        .yc          (yc),
        .hsync_in    (hsync_in),
        .vsync_in    (vsync_in),
        .hblank_in   (hblank_in),
        .vblank_in   (vblank_in),
        .pal         (pal),
        .pal_temp    (pal_temp),
        .pal_wr      (pal_wr),
        .pal_wr_addr (pal_wr_addr),
        .pal_wr_data (pal_wr_data),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .hsync       (hsync),
        .vsync       (vsync),
        .hblank      (hblank),
        .vblank      (vblank),
        .ce_pix      (ce_pix)
    );

    assign rgb = {red, green, blue};

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One pixel strobe with the given inputs. The task returns on the
    // falling edge after the strobe edge, where the outputs are checked.
    task automatic strobe(input logic [7:0] y, input logic hs, input logic vs,
                          input logic hb, input logic vb);
        @(negedge clk_sys);
        yc = y; hsync_in = hs; vsync_in = vs; hblank_in = hb; vblank_in = vb;
        mclk0 = 1'b1;
        @(negedge clk_sys);
        mclk0 = 1'b0;
    endtask

    initial begin
        reset_b = 1'b0; mclk0 = 1'b0; yc = 8'h00;
        hsync_in = 1'b0; vsync_in = 1'b0; hblank_in = 1'b0; vblank_in = 1'b0;
        pal = 1'b0; pal_temp = 2'd0;
        pal_wr = 1'b0; pal_wr_addr = 11'd0; pal_wr_data = 24'd0;

        // Reset state
        repeat (3) @(negedge clk_sys);
        check("rst_rgb",    rgb, BLANK);
        check("rst_hsync",  {23'd0, hsync},  24'd0);
        check("rst_vsync",  {23'd0, vsync},  24'd0);
        check("rst_hblank", {23'd0, hblank}, 24'd1);
        check("rst_vblank", {23'd0, vblank}, 24'd1);
        check("rst_ce",     {23'd0, ce_pix}, 24'd0);
        reset_b = 1'b1;

        // Basic two-strobe latency
        strobe(8'h0F, 1'b1, 1'b0, 1'b0, 1'b0);
        check("lat_s1_rgb",    rgb, BLANK);
        check("lat_s1_hblank", {23'd0, hblank}, 24'd1);
        check("lat_s1_ce",     {23'd0, ce_pix}, 24'd1);
        strobe(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lat_s2_rgb",    rgb, S0_0F);
        check("lat_s2_hsync",  {23'd0, hsync},  24'd1);
        check("lat_s2_hblank", {23'd0, hblank}, 24'd0);
        check("lat_s2_ce",     {23'd0, ce_pix}, 24'd1);
        yc = 8'h1A;
        @(negedge clk_sys);
        check("idle_ce",  {23'd0, ce_pix}, 24'd0);
        repeat (3) @(negedge clk_sys);
        check("idle_rgb", rgb, S0_0F);
        check("idle_hs",  {23'd0, hsync}, 24'd1);
        strobe(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        check("lat_s3_rgb",   rgb, S0_0F);
        check("lat_s3_hsync", {23'd0, hsync}, 24'd0);

        // Single-pixel hblank
        strobe(8'h1A, 1'b0, 1'b0, 1'b1, 1'b0);
        check("hb_prev_rgb", rgb, S0_0F);
        strobe(8'h35, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hb_pix_rgb",    rgb, BLANK);
        check("hb_pix_hblank", {23'd0, hblank}, 24'd1);
        strobe(8'h1A, 1'b0, 1'b0, 1'b0, 1'b0);
        check("hb_next_rgb",    rgb, S0_35);
        check("hb_next_hblank", {23'd0, hblank}, 24'd0);
        strobe(8'h1A, 1'b0, 1'b0, 1'b0, 1'b0);
        check("s0_1a_rgb", rgb, S0_1A);

        // Mid-frame bank switch waits for the vsync rising edge
        pal = 1'b1;
        strobe(8'h35, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pal_mid_a", rgb, S0_1A);
        strobe(8'h35, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pal_mid_b", rgb, S0_35);
        strobe(8'h1A, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pal_mid_c", rgb, S0_35);
        check("vs_out_lo", {23'd0, vsync}, 24'd0);
        strobe(8'h35, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pal_set4_1a", rgb, S4_1A);
        check("vs_out_hi",   {23'd0, vsync}, 24'd1);
        pal = 1'b0; pal_temp = 2'd1;
        strobe(8'h1A, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pal_set4_35", rgb, S4_35);
        pal = 1'b1; pal_temp = 2'd0;
        strobe(8'h1A, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pal_hold_set4", rgb, S4_1A);
        // vsync rise and select change on the same strobe
        pal = 1'b0; pal_temp = 2'd1;
        strobe(8'h1A, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pal_same_a", rgb, S4_1A);
        strobe(8'h35, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pal_set1_1a", rgb, S1_1A);
        pal_temp = 2'd0;
        strobe(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pal_set1_35", rgb, S1_35);
        strobe(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        check("pal_set1_ff", rgb, S1_FF);

        // Write colliding with the read of set 0 index FF
        @(negedge clk_sys);
        yc = 8'hFF; vsync_in = 1'b1; mclk0 = 1'b1;
        pal_wr = 1'b1; pal_wr_addr = 11'h0FF; pal_wr_data = 24'h123456;
        @(negedge clk_sys);
        mclk0 = 1'b0; pal_wr = 1'b0;
        check("wr_collide_old", rgb, S0_FF);
        strobe(8'hFF, 1'b0, 1'b1, 1'b0, 1'b0);
        check("wr_next_read", rgb, EXP_FF_NEW);
        // Write on a cycle without a strobe
        @(negedge clk_sys);
        pal_wr = 1'b1; pal_wr_addr = 11'h01A; pal_wr_data = 24'hABCDEF;
        @(negedge clk_sys);
        pal_wr = 1'b0;
        check("wr_nostrobe_hold", rgb, EXP_FF_NEW);
        strobe(8'h1A, 1'b0, 1'b1, 1'b0, 1'b0);
        check("wr_ff_again", rgb, EXP_FF_NEW);
        strobe(8'h1A, 1'b0, 1'b1, 1'b0, 1'b0);
        check("wr_1a_read", rgb, EXP_1A_NEW);

        // Move to set 4, then reset mid-line
        pal = 1'b1;
        strobe(8'h35, 1'b0, 1'b0, 1'b0, 1'b0);
        strobe(8'h35, 1'b0, 1'b1, 1'b0, 1'b0);
        strobe(8'h35, 1'b0, 1'b0, 1'b0, 1'b0);
        check("pre_rst_rgb",   rgb, S4_35);
        check("pre_rst_vsync", {23'd0, vsync}, 24'd1);
        #2 reset_b = 1'b0;
        #1;
        check("arst_rgb",    rgb, BLANK);
        check("arst_hblank", {23'd0, hblank}, 24'd1);
        check("arst_vblank", {23'd0, vblank}, 24'd1);
        check("arst_vsync",  {23'd0, vsync},  24'd0);
        check("arst_ce",     {23'd0, ce_pix}, 24'd0);
        #9 reset_b = 1'b1;
        strobe(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_1st", rgb, BLANK);
        strobe(8'h35, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_2nd", rgb, EXP_FF_NEW);
        strobe(8'h35, 1'b0, 1'b0, 1'b0, 1'b0);
        check("post_rst_set0", rgb, S0_35);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
